// File: rtl/spi_ram_pkg.sv
// ============================================================================
// Module   : spi_ram_pkg
// Brief    : Command codes and TX state encoding for the SPI RAM controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int CMD_MSB = 9;
  localparam int CMD_LSB = 8;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_ram_array.sv
// ============================================================================
// Module   : spi_ram_array
// Brief    : Byte-wide synchronous RAM with a registered read port; accesses
//            beyond MEM_DEPTH are dropped on write and read back as zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_ram_array #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  logic [7:0]           i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output logic [7:0]           o_rdata
);

  // One extra bit so a full 2^ADDR_SIZE depth is representable.
  localparam logic [ADDR_SIZE:0] C_DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);

  logic [7:0] r_mem [MEM_DEPTH];
  logic [7:0] r_rdata;
  logic       w_waddr_ok;
  logic       w_raddr_ok;

  assign w_waddr_ok = {1'b0, i_waddr} < C_DEPTH;
  assign w_raddr_ok = {1'b0, i_raddr} < C_DEPTH;

  always_ff @(posedge clk) begin
    if (i_we && w_waddr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= w_raddr_ok ? r_mem[i_raddr] : 8'h00;
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
// ============================================================================
// Module   : spi_ram_ctrl
// Brief    : Command decoder, address registers and tx_valid hold timer in
//            front of spi_ram_array. Optional macro RAM_ADDR_AUTOINC_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  import spi_ram_pkg::*;

  localparam logic [3:0]           C_HOLD_LOAD = 4'(TX_HOLD - 1);
  localparam logic [ADDR_SIZE-1:0] C_ADDR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);

  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic                 r_dout_vld;
  logic [1:0]           w_cmd;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [7:0]           w_rdata;

  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    return (a == C_ADDR_LAST) ? '0 : a + 1'b1;
  endfunction

  assign w_cmd   = din[CMD_MSB:CMD_LSB];
  assign w_wr_en = rx_valid && (w_cmd == CMD_WR_DATA);
  assign w_rd_en = rx_valid && (w_cmd == CMD_RD_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else if (rx_valid) begin
      case (w_cmd)
        CMD_WR_ADDR: r_wr_addr <= din[ADDR_SIZE-1:0];
        CMD_RD_ADDR: r_rd_addr <= din[ADDR_SIZE-1:0];
`ifdef RAM_ADDR_AUTOINC_EN
        CMD_WR_DATA: r_wr_addr <= addr_inc(r_wr_addr);
        CMD_RD_DATA: r_rd_addr <= addr_inc(r_rd_addr);
`endif
        default: ;
      endcase
    end
  end

  spi_ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_addr),
    .i_wdata (din[7:0]),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rdata)
  );

  // The array read register has no reset, so dout is gated until a read lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= spi_ram_pkg::TX_IDLE;
      r_cnt      <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_rd_en) begin
        r_dout_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      spi_ram_pkg::TX_IDLE: begin
        if (w_rd_en) begin
          w_state_nxt = spi_ram_pkg::TX_HOLD;
          w_cnt_nxt   = C_HOLD_LOAD;
        end
      end
      spi_ram_pkg::TX_HOLD: begin
        if (w_rd_en) begin
          w_cnt_nxt = C_HOLD_LOAD;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = spi_ram_pkg::TX_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = spi_ram_pkg::TX_IDLE;
    endcase
  end

  assign dout     = r_dout_vld ? w_rdata : 8'h00;
  assign tx_valid = (r_state == spi_ram_pkg::TX_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
// ============================================================================
// Module   : tb_spi_ram_ctrl
// Brief    : Directed bench for spi_ram_ctrl: a default instance and a
//            MEM_DEPTH=200 / TX_HOLD=3 instance driven by the same commands.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout0, dout1;
  logic       txv0, txv1;

  int checks   = 0;
  int failures = 0;
  int run0 = 0, last0 = 0;
  int run1 = 0, last1 = 0;

  spi_ram_ctrl u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout0),
    .tx_valid (txv0)
  );

  spi_ram_ctrl #(
    .MEM_DEPTH (200),
    .ADDR_SIZE (8),
    .TX_HOLD   (3)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout1),
    .tx_valid (txv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Length of the most recently completed tx_valid run, per instance.
  always @(negedge clk) begin
    if (txv0) run0 = run0 + 1;
    else if (run0 != 0) begin last0 = run0; run0 = 0; end
    if (txv1) run1 = run1 + 1;
    else if (run1 != 0) begin last1 = run1; run1 = 0; end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Presents one command for exactly one rising edge; returns on the next negedge.
  task automatic cmd(input logic [1:0] c, input logic [7:0] p);
    din      = {c, p};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((txv0 || txv1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("wait_idle_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    din      = '0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txv0", 32'(txv0), 32'd0);
    chk("rst_dout0", 32'(dout0), 32'h00);
    chk("rst_txv1", 32'(txv1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0xA5 to address 5.
    cmd(2'b00, 8'h05);
    cmd(2'b01, 8'hA5);
    chk("t1_txv", 32'(txv0), 32'd0);
    chk("t1_dout", 32'(dout0), 32'h00);

    // Read it back; hold window 8 (dut0) and 3 (dut1).
    cmd(2'b10, 8'h05);
    cmd(2'b11, 8'h00);
    chk("t2_dout", 32'(dout0), 32'hA5);
    chk("t2_txv", 32'(txv0), 32'd1);
    chk("t2_dout1", 32'(dout1), 32'hA5);
    wait_idle();
    chk("t2_run0", 32'(last0), 32'd8);
    chk("t2_run1", 32'(last1), 32'd3);
    chk("t2_dout_hold", 32'(dout0), 32'hA5);
    chk("t2_txv_off", 32'(txv0), 32'd0);

    // Restart mid-hold: RD_DATA, RD_ADDR 6, idle, RD_DATA.
    cmd(2'b00, 8'h06);
    cmd(2'b01, 8'h3C);
    cmd(2'b11, 8'h00);
`ifdef RAM_ADDR_AUTOINC_EN
    chk("t3_dout_a", 32'(dout0), 32'h3C);
`else
    chk("t3_dout_a", 32'(dout0), 32'hA5);
`endif
    cmd(2'b10, 8'h06);
    @(negedge clk);
    cmd(2'b11, 8'h00);
    chk("t3_dout_b", 32'(dout0), 32'h3C);
    chk("t3_txv", 32'(txv0), 32'd1);
    wait_idle();
    chk("t3_run0", 32'(last0), 32'd11);
    chk("t3_run1", 32'(last1), 32'd6);

    // Write then read the same address on the very next edge.
    cmd(2'b00, 8'h07);
    cmd(2'b10, 8'h07);
    cmd(2'b01, 8'h11);
    cmd(2'b11, 8'h00);
    chk("t4_dout", 32'(dout0), 32'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_txv0", 32'(txv0), 32'd0);
    chk("t4_rst_txv1", 32'(txv1), 32'd0);
    chk("t4_rst_dout", 32'(dout0), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_post_txv", 32'(txv0), 32'd0);
    cmd(2'b10, 8'h07);
    cmd(2'b11, 8'h00);
    chk("t4_mem_kept", 32'(dout0), 32'h11);
    wait_idle();

    // Out-of-range for the 200-deep instance.
    cmd(2'b00, 8'hD0);
    cmd(2'b01, 8'hFF);
    cmd(2'b10, 8'hD0);
    cmd(2'b11, 8'h00);
    chk("t5_dout0", 32'(dout0), 32'hFF);
    chk("t5_dout1", 32'(dout1), 32'h00);
    chk("t5_txv1", 32'(txv1), 32'd1);
    wait_idle();

    // Address 0xFF then two writes and two reads.
    cmd(2'b00, 8'hFF);
    cmd(2'b01, 8'h01);
    cmd(2'b01, 8'h02);
    cmd(2'b10, 8'hFF);
    cmd(2'b11, 8'h00);
`ifdef RAM_ADDR_AUTOINC_EN
    chk("t6_rd1_dut0", 32'(dout0), 32'h01);
`else
    chk("t6_rd1_dut0", 32'(dout0), 32'h02);
`endif
    chk("t6_rd1_dut1", 32'(dout1), 32'h00);
    cmd(2'b11, 8'h00);
`ifdef RAM_ADDR_AUTOINC_EN
    chk("t6_rd2_dut0", 32'(dout0), 32'h02);
    chk("t6_rd2_dut1", 32'(dout1), 32'h02);
`else
    chk("t6_rd2_dut0", 32'(dout0), 32'h02);
    chk("t6_rd2_dut1", 32'(dout1), 32'h00);
`endif
    wait_idle();

    // Last in-range word of the 200-deep instance.
    cmd(2'b00, 8'hC7);
    cmd(2'b01, 8'h5A);
    cmd(2'b01, 8'h6B);
    cmd(2'b10, 8'hC7);
    cmd(2'b11, 8'h00);
`ifdef RAM_ADDR_AUTOINC_EN
    chk("t7_rd1_dut0", 32'(dout0), 32'h5A);
    chk("t7_rd1_dut1", 32'(dout1), 32'h5A);
    cmd(2'b11, 8'h00);
    chk("t7_rd2_dut0", 32'(dout0), 32'h6B);
    chk("t7_rd2_dut1", 32'(dout1), 32'h6B);
`else
    chk("t7_rd1_dut0", 32'(dout0), 32'h6B);
    chk("t7_rd1_dut1", 32'(dout1), 32'h6B);
`endif
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
